store_buffer_fwd: RTL and testbench
===================================

// Module: store_buffer_fwd
// PURPOSE
// - Parametrised posted-store buffer between the NPORT memory-stage lanes of the VLIW core and the data BRAM.
// - Absorbs up to NPORT stores/cycle and drains one store/cycle to the BRAM write port.
// - Forwards the youngest buffered (or in-flight) store data to each load lane, so loads never see stale BRAM.
// - Adds over the previous generation: depth/width/lane parameters, occupancy-based stall, overflow flag, explicit drained status.
// PARAMETERS
// - NPORT  2   number of load/store lanes (1..4); lower index = older in program order
// - DEPTH  8   buffer entries, power of two, DEPTH >= 2*NPORT
// - AW     32  address width (word address as produced by the ALU)
// - DW     32  data width
// PORTS
// - clk        in   1         clock
// - rstn       in   1         reset, synchronous, active-low
// - st_en      in   NPORT     per-lane store request this cycle
// - st_addr    in   NPORT*AW  per-lane store address, lane i at [i*AW +: AW]
// - st_data    in   NPORT*DW  per-lane store data
// - ld_addr    in   NPORT*AW  per-lane load address (also fed to BRAM read port by parent)
// - mem_rdata  in   NPORT*DW  BRAM read data, 1-cycle latency after ld_addr
// - ld_data    out  NPORT*DW  per-lane load result, valid 1 cycle after ld_addr
// - mem_we     out  1         BRAM write enable (registered)
// - mem_waddr  out  AW        BRAM write address (registered)
// - mem_wdata  out  DW        BRAM write data (registered)
// - stall      out  1         free entries < NPORT; core must not issue stores
// - drained    out  1         buffer empty and mem_we low
// - ovf        out  1         sticky: store dropped because buffer full
// BEHAVIOUR
// - Reset (rstn=0 at clk edge): wr_ptr=rd_ptr=0, count=0, mem_we=0, mem_waddr=mem_wdata=0, fwd hits=0, ovf=0.
//   Entries are not cleared. stall=0, drained=1 after reset.
//   Reset mid-operation discards all pending stores without draining them.
// - Enqueue: set lanes of st_en are appended in ascending lane order at wr_ptr, wr_ptr+1, ...
//   Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
// - Drain: if count!=0 then mem_we<=1, {mem_waddr,mem_wdata}<=entry[rd_ptr], rd_ptr++; else mem_we<=0.
// - Occupancy: count_next = count + popcount(accepted st_en) - drain.
//   Enqueue and drain in the same cycle is legal at any count, including count==DEPTH.
// - stall = (DEPTH - count) < NPORT, from registered count (combinational output, no input dependence).
// - Overflow: a lane's store is accepted only if an entry is free after the older lanes.
//   Rejected stores are dropped and set ovf (cleared only by reset).
// - Forwarding, per lane j, evaluated against state at the clock edge:
//   - candidates: valid entries (age index 0..count-1 from rd_ptr), plus the in-flight drain register (mem_we=1).
//   - youngest matching valid entry wins; the in-flight register ranks oldest.
//   - on a match: fwd_hit[j]<=1, fwd_data[j]<=data; otherwise fwd_hit[j]<=0.
//   - stores presented in the same cycle as the load are NOT forwarded; the load sees prior state.
// - ld_data[j] = fwd_hit[j] ? fwd_data[j] : mem_rdata[j]. Total latency matches BRAM: 1 cycle.
// - Address compare is full AW bits; no partial/byte overlap handling (word stores only).
// - Validity is derived from pointers and count, never from stale entry contents.
//   Entries outside the valid window never match, including after wrap.
// - drained = (count==0) && !mem_we.
// STRUCTURE
// - Shared package constants: SB_PTR_W = $clog2(DEPTH), SB_CNT_W = $clog2(DEPTH)+1, lane slice helpers.
// - Sub-module sb_fwd_match, instantiated NPORT times:
//   - inputs: address, ADDR/DATA arrays, rd_ptr, count, in-flight register
//   - outputs: hit and data
//   - youngest-first priority over age-ordered entries
// - ADDR/DATA arrays are distributed RAM/flops (multi-read); the enqueue and pointer/count logic stays in the top.
// TESTING
// - Single store lane0 @0x10=0xAA, load lane1 @0x10 next cycle -> ld_data=0xAA from buffer; BRAM holds 0xAA after drain.
// - Two same-address stores in one bundle (lane0=1, lane1=2 @0x20), then load -> 2; drained rises 2 cycles later.
// - Store @0x30=5 and load @0x30 in the same cycle -> old BRAM value; load next cycle -> 5.
// - Fill with NPORT stores/cycle -> stall asserts at count>DEPTH-NPORT. Force one extra store at full -> ovf=1, that store is absent from BRAM.
// - Wrap: 3*DEPTH sequential stores to distinct addresses.
//   Load of an address whose entry has drained and been overwritten in its slot -> BRAM data, no false hit.
// - Assert rstn with 5 pending stores -> count=0, mem_we=0, drained=1 next cycle; pending stores never reach BRAM.

Source files
------------

// File: rtl/store_buffer_fwd_pkg.sv
// Shared constants and helpers for the posted-store buffer.
// Holds the default lane/depth/width configuration, the pointer and
// occupancy widths derived from it, and the lane-slice helper used to
// address the flattened per-lane buses.
package store_buffer_fwd_pkg;

    localparam int unsigned SB_NPORT = 2;
    localparam int unsigned SB_DEPTH = 8;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;

    // Pointer wraps modulo DEPTH; count needs one more bit to hold DEPTH itself.
    localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned SB_CNT_W = $clog2(SB_DEPTH) + 1;

    // Low bit of lane `lane` inside a flattened NPORT*w bus.
    function automatic int unsigned sb_lane_lo(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/store_buffer_fwd_if.sv
// Memory-stage bus between the core lanes / BRAM and the store buffer.
// Signals:
//   st_en/st_addr/st_data  per-lane store request, address, data
//   ld_addr                per-lane load address (also sent to BRAM by parent)
//   mem_rdata              BRAM read data, 1 cycle after ld_addr
//   ld_data                per-lane load result, 1 cycle after ld_addr
//   mem_we/waddr/wdata     BRAM write port
//   stall/drained/ovf      status
// master = core/parent side, slave = store buffer.
interface store_buffer_fwd_if #(
    parameter int unsigned NPORT = store_buffer_fwd_pkg::SB_NPORT,
    parameter int unsigned AW    = store_buffer_fwd_pkg::SB_AW,
    parameter int unsigned DW    = store_buffer_fwd_pkg::SB_DW
);
    logic [NPORT-1:0]    st_en;
    logic [NPORT*AW-1:0] st_addr;
    logic [NPORT*DW-1:0] st_data;
    logic [NPORT*AW-1:0] ld_addr;
    logic [NPORT*DW-1:0] mem_rdata;
    logic [NPORT*DW-1:0] ld_data;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [DW-1:0]       mem_wdata;
    logic                stall;
    logic                drained;
    logic                ovf;

    modport master (
        output st_en, st_addr, st_data, ld_addr, mem_rdata,
        input  ld_data, mem_we, mem_waddr, mem_wdata, stall, drained, ovf
    );

    modport slave (
        input  st_en, st_addr, st_data, ld_addr, mem_rdata,
        output ld_data, mem_we, mem_waddr, mem_wdata, stall, drained, ovf
    );

endinterface

// File: rtl/sb_fwd_match.sv
// Per-lane forwarding lookup: finds the youngest buffered store whose
// address equals ld_addr.
// Ports:
//   ld_addr              load address of this lane
//   ent_addr/ent_data    buffer storage, indexed by slot
//   rd_ptr/count         valid window: ages 0..count-1 starting at rd_ptr
//   inf_we/addr/data     store currently on the BRAM write port (oldest candidate)
//   hit_c/data_c         combinational match result
module sb_fwd_match import store_buffer_fwd_pkg::*; #(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic [AW-1:0]    ld_addr,
    input  logic [AW-1:0]    ent_addr [DEPTH],
    input  logic [DW-1:0]    ent_data [DEPTH],
    input  logic [PTR_W-1:0] rd_ptr,
    input  logic [CNT_W-1:0] count,
    input  logic             inf_we,
    input  logic [AW-1:0]    inf_addr,
    input  logic [DW-1:0]    inf_data,
    output logic             hit_c,
    output logic [DW-1:0]    data_c
);

    // Scan oldest to youngest so a later (younger) match overrides an earlier one.
    // Validity comes only from the age window, never from slot contents.
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        if (inf_we && (inf_addr == ld_addr)) begin
            hit_c  = 1'b1;
            data_c = inf_data;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (ent_addr[rd_ptr + PTR_W'(k)] == ld_addr)) begin
                hit_c  = 1'b1;
                data_c = ent_data[rd_ptr + PTR_W'(k)];
            end
        end
    end

endmodule

// File: rtl/store_buffer_fwd.sv
// Posted-store buffer between the NPORT memory-stage lanes and the data BRAM.
// Accepts up to NPORT stores per cycle (lower lane = older), drains one per
// cycle to the BRAM write port, and forwards the youngest pending store to
// each load lane so loads never observe stale BRAM contents.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   sb          store_buffer_fwd_if slave modport (store/load lanes, BRAM
//               write port, BRAM read data, stall/drained/ovf status)
module store_buffer_fwd import store_buffer_fwd_pkg::*; #(
    parameter int unsigned NPORT = SB_NPORT,
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic              clk,
    input  logic              rstn,
    store_buffer_fwd_if.slave sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Storage (no reset: validity comes from pointers and count)
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [DW-1:0]    mem_wdata;
    logic             ovf;

    logic [NPORT-1:0] fwd_hit;
    logic [DW-1:0]    fwd_data [NPORT];

    logic             drain_c;
    logic [CNT_W-1:0] avail_c;
    logic [NPORT-1:0] acc_c;
    logic [CNT_W-1:0] slot_c [NPORT];
    logic [CNT_W-1:0] n_acc_c;
    logic             rej_c;

    logic             match_hit_c  [NPORT];
    logic [DW-1:0]    match_data_c [NPORT];
    logic [NPORT*DW-1:0] ld_data_c;

    assign drain_c = (count != '0);

    // Lane acceptance: the slot leaving through the drain this cycle is
    // reusable, so a full buffer still takes one store while draining.
    always_comb begin
        avail_c = CNT_W'(DEPTH) - count + CNT_W'(drain_c);
        n_acc_c = '0;
        acc_c   = '0;
        rej_c   = 1'b0;
        slot_c  = '{default: '0};
        for (int unsigned i = 0; i < NPORT; i++) begin
            slot_c[i] = n_acc_c;
            if (sb.st_en[i]) begin
                if (n_acc_c < avail_c) begin
                    acc_c[i] = 1'b1;
                    n_acc_c  = n_acc_c + CNT_W'(1);
                end else begin
                    rej_c = 1'b1;
                end
            end
        end
    end

    // Entry writes, packed in lane order from wr_ptr
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (acc_c[i]) begin
                ent_addr[wr_ptr + PTR_W'(slot_c[i])] <= sb.st_addr[sb_lane_lo(i, AW) +: AW];
                ent_data[wr_ptr + PTR_W'(slot_c[i])] <= sb.st_data[sb_lane_lo(i, DW) +: DW];
            end
        end
    end

    // Pointers, occupancy, drain register and sticky overflow
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            ovf       <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_acc_c);
            count  <= count + n_acc_c - CNT_W'(drain_c);
            mem_we <= drain_c;
            if (drain_c) begin
                mem_waddr <= ent_addr[rd_ptr];
                mem_wdata <= ent_data[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
            end
            if (rej_c) begin
                ovf <= 1'b1;
            end
        end
    end

    // One lookup per load lane against pre-edge state
    for (genvar j = 0; j < NPORT; j++) begin : g_lane
        sb_fwd_match #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .DW    (DW),
            .PTR_W (PTR_W),
            .CNT_W (CNT_W)
        ) u_match (
            .ld_addr  (sb.ld_addr[j*AW +: AW]),
            .ent_addr (ent_addr),
            .ent_data (ent_data),
            .rd_ptr   (rd_ptr),
            .count    (count),
            .inf_we   (mem_we),
            .inf_addr (mem_waddr),
            .inf_data (mem_wdata),
            .hit_c    (match_hit_c[j]),
            .data_c   (match_data_c[j])
        );
    end

    // Forward result registered to line up with the 1-cycle BRAM read
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fwd_hit  <= '0;
            fwd_data <= '{default: '0};
        end else begin
            for (int unsigned j = 0; j < NPORT; j++) begin
                fwd_hit[j]  <= match_hit_c[j];
                fwd_data[j] <= match_data_c[j];
            end
        end
    end

    // Load result: buffered data overrides BRAM data
    always_comb begin
        ld_data_c = '0;
        for (int unsigned j = 0; j < NPORT; j++) begin
            ld_data_c[j*DW +: DW] = fwd_hit[j] ? fwd_data[j] : sb.mem_rdata[j*DW +: DW];
        end
    end

    assign sb.ld_data   = ld_data_c;
    assign sb.mem_we    = mem_we;
    assign sb.mem_waddr = mem_waddr;
    assign sb.mem_wdata = mem_wdata;
    assign sb.stall     = (CNT_W'(DEPTH) - count) < CNT_W'(NPORT);
    assign sb.drained   = (count == '0) && !mem_we;
    assign sb.ovf       = ovf;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Bench for store_buffer_fwd: BRAM model, program-order memory model with a
// pending-store queue checked every cycle, plus directed literal checks.
module tb_store_buffer_fwd;

    localparam int unsigned NPORT = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam logic [31:0] IDLE_A = 32'h0000_FFF0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    store_buffer_fwd_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) sb_if ();

    store_buffer_fwd #(.NPORT(NPORT), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sb   (sb_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- environment + model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    logic [31:0] bram [logic [31:0]];   // physical BRAM contents
    logic [31:0] gold [logic [31:0]];   // memory as program order says it should be
    st_t         q [$];                 // stores accepted but not yet on the write port
    logic        exp_mem_we = 1'b0;
    logic [31:0] exp_waddr  = '0;
    logic [31:0] exp_wdata  = '0;
    logic        exp_ovf    = 1'b0;
    logic [31:0] exp_ld [NPORT];
    logic        ld_chk     = 1'b0;
    logic        model_live = 1'b0;

    function automatic logic [31:0] rd_bram(input logic [31:0] a);
        return bram.exists(a) ? bram[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_gold(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        int  avail;
        st_t s;
        // BRAM: read returns the pre-edge contents, then the write port lands
        for (int j = 0; j < NPORT; j++)
            sb_if.mem_rdata[j*DW +: DW] <= rd_bram(sb_if.ld_addr[j*AW +: AW]);
        if (sb_if.mem_we)
            bram[sb_if.mem_waddr] = sb_if.mem_wdata;

        if (!rstn) begin
            q.delete();
            exp_mem_we = 1'b0;
            exp_waddr  = '0;
            exp_wdata  = '0;
            exp_ovf    = 1'b0;
            gold       = bram;
            ld_chk     = 1'b0;
            model_live = 1'b1;
        end else begin
            // A load sees every store accepted at earlier edges
            for (int j = 0; j < NPORT; j++)
                exp_ld[j] = rd_gold(sb_if.ld_addr[j*AW +: AW]);
            ld_chk = 1'b1;
            avail = int'(DEPTH) - q.size() + ((q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
                s          = q.pop_front();
                exp_mem_we = 1'b1;
                exp_waddr  = s.addr;
                exp_wdata  = s.data;
            end else begin
                exp_mem_we = 1'b0;
            end
            for (int i = 0; i < NPORT; i++) begin
                if (sb_if.st_en[i]) begin
                    if (avail > 0) begin
                        s.addr = sb_if.st_addr[i*AW +: AW];
                        s.data = sb_if.st_data[i*DW +: DW];
                        q.push_back(s);
                        gold[s.addr] = s.data;
                        avail--;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_live) begin
            chk("mem_we", 32'(sb_if.mem_we), 32'(exp_mem_we));
            if (exp_mem_we) begin
                chk("mem_waddr", sb_if.mem_waddr, exp_waddr);
                chk("mem_wdata", sb_if.mem_wdata, exp_wdata);
            end
            chk("stall", 32'(sb_if.stall), 32'((int'(DEPTH) - q.size()) < int'(NPORT)));
            chk("drained", 32'(sb_if.drained), 32'((q.size() == 0) && !exp_mem_we));
            chk("ovf", 32'(sb_if.ovf), 32'(exp_ovf));
            if (ld_chk)
                for (int j = 0; j < NPORT; j++)
                    chk($sformatf("ld_data[%0d]", j), sb_if.ld_data[j*DW +: DW], exp_ld[j]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.st_en = '0;
    endtask

    task automatic st(input int lane, input logic [31:0] a, input logic [31:0] d);
        sb_if.st_en[lane]             = 1'b1;
        sb_if.st_addr[lane*AW +: AW] = a;
        sb_if.st_data[lane*DW +: DW] = d;
    endtask

    task automatic ld(input int lane, input logic [31:0] a);
        sb_if.ld_addr[lane*AW +: AW] = a;
    endtask

    function automatic logic [31:0] ldd(input int lane);
        return sb_if.ld_data[lane*DW +: DW];
    endfunction

    task automatic wait_drained(input int maxc);
        int c = 0;
        while (!sb_if.drained && c < maxc) begin
            tick();
            c++;
        end
        chk("drain_timeout", 32'(sb_if.drained), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        sb_if.st_en   = '0;
        sb_if.st_addr = '0;
        sb_if.st_data = '0;
        ld(0, IDLE_A);
        ld(1, IDLE_A);
        bram[32'h30] = 32'h77;

        rstn = 1'b0;
        tick();
        tick();
        chk("rst_mem_we",    32'(sb_if.mem_we),  32'd0);
        chk("rst_mem_waddr", sb_if.mem_waddr,    32'd0);
        chk("rst_mem_wdata", sb_if.mem_wdata,    32'd0);
        chk("rst_stall",     32'(sb_if.stall),   32'd0);
        chk("rst_drained",   32'(sb_if.drained), 32'd1);
        chk("rst_ovf",       32'(sb_if.ovf),     32'd0);
        rstn = 1'b1;

        // single store, forwarded to the other lane next cycle
        st(0, 32'h10, 32'hAA);
        tick();
        idle();
        ld(1, 32'h10);
        tick();
        chk("t1_fwd", ldd(1), 32'hAA);
        ld(1, IDLE_A);
        wait_drained(20);
        chk("t1_bram", rd_bram(32'h10), 32'hAA);

        // same-address pair in one bundle: younger lane wins
        st(0, 32'h20, 32'h1);
        st(1, 32'h20, 32'h2);
        tick();
        idle();
        ld(0, 32'h20);
        tick();
        chk("t2_fwd", ldd(0), 32'h2);
        chk("t2_drained_c1", 32'(sb_if.drained), 32'd0);
        ld(0, IDLE_A);
        tick();
        chk("t2_drained_c2", 32'(sb_if.drained), 32'd0);
        tick();
        chk("t2_drained_c3", 32'(sb_if.drained), 32'd1);
        chk("t2_bram", rd_bram(32'h20), 32'h2);

        // store and load in the same cycle: load sees prior state
        st(0, 32'h30, 32'h5);
        ld(1, 32'h30);
        tick();
        chk("t3_same_cycle", ldd(1), 32'h77);
        idle();
        tick();
        chk("t3_next_cycle", ldd(1), 32'h5);
        ld(1, IDLE_A);
        wait_drained(20);

        // fill at two stores per cycle, then overflow at full
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                st(0, 32'h100 + 32'(2*k), 32'h4000 + 32'(2*k));
                st(1, 32'h101 + 32'(2*k), 32'h4001 + 32'(2*k));
            end else begin
                st(0, 32'h1F0, 32'hBEEF);
                st(1, 32'h1FF, 32'hDEAD);
            end
            tick();
            if (k == 4) chk("t4_stall_cnt6", 32'(sb_if.stall), 32'd0);
            if (k == 5) chk("t4_stall_cnt7", 32'(sb_if.stall), 32'd1);
            if (k == 6) chk("t4_ovf_before", 32'(sb_if.ovf),   32'd0);
            if (k == 7) chk("t4_ovf_after",  32'(sb_if.ovf),   32'd1);
        end
        idle();
        wait_drained(40);
        chk("t4_dropped_absent", 32'(bram.exists(32'h1FF)), 32'd0);
        chk("t4_lane0_kept", rd_bram(32'h1F0), 32'hBEEF);

        // wrap three times, then make BRAM differ from the stale slots
        for (int k = 0; k < 3*int'(DEPTH); k++) begin
            st(0, 32'h200 + 32'(k), 32'h5000 + 32'(k));
            tick();
        end
        idle();
        wait_drained(20);
        for (int k = 0; k < int'(DEPTH); k++) begin
            bram[32'h210 + 32'(k)] = 32'hC000 + 32'(k);
            gold[32'h210 + 32'(k)] = 32'hC000 + 32'(k);
        end
        for (int k = 0; k < int'(DEPTH); k += 2) begin
            ld(0, 32'h210 + 32'(k));
            ld(1, 32'h211 + 32'(k));
            tick();
            chk("t5_stale_l0", ldd(0), 32'hC000 + 32'(k));
            chk("t5_stale_l1", ldd(1), 32'hC001 + 32'(k));
        end
        ld(0, IDLE_A);
        ld(1, IDLE_A);

        // reset with five stores pending in the buffer
        for (int k = 0; k < 4; k++) begin
            st(0, 32'h300 + 32'(2*k), 32'h6000 + 32'(2*k));
            st(1, 32'h301 + 32'(2*k), 32'h6001 + 32'(2*k));
            tick();
        end
        idle();
        rstn = 1'b0;
        tick();
        chk("t6_drained", 32'(sb_if.drained), 32'd1);
        chk("t6_mem_we",  32'(sb_if.mem_we),  32'd0);
        chk("t6_ovf",     32'(sb_if.ovf),     32'd0);
        rstn = 1'b1;
        tick();
        tick();
        chk("t6_inflight_written", rd_bram(32'h302), 32'h6002);
        for (int k = 3; k < 8; k++)
            chk($sformatf("t6_lost_%0h", 32'h300 + 32'(k)), 32'(bram.exists(32'h300 + 32'(k))), 32'd0);

        // final image: BRAM must equal program-order memory
        wait_drained(20);
        foreach (gold[a])
            chk($sformatf("final_bram_%0h", a), rd_bram(a), gold[a]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
